led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_seq_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/led_pattern_seq.sv | 134 +++++++++++++
 tb/tb_led_pattern_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, sequencer
// states and the bounce direction.
package led_seq_pkg;

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    SHIFT  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } bounce_dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV cycle counter. Counts only while en=1, holds otherwise;
// clr forces it back to zero. tc marks the enabled cycle at count DIV-1.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign tc     = en & w_last;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps one of four patterns at STEP_HZ while running.
// Build option: define LED_ACTIVE_LOW_EN to drive leds inverted (dark = 1).
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int CLOCK_XTAL = 27000000,
  parameter int LED_NUM    = 6,
  parameter int STEP_HZ    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mode_req,
  input  logic [1:0]         mode_sel,
  output logic               mode_ack,
  output logic [LED_NUM-1:0] leds,
  output logic               step_tick
);

  localparam int DIV = CLOCK_XTAL / STEP_HZ;

  generate
    if (DIV < 2 || LED_NUM < 2) begin : g_param_check
      $error("led_pattern_seq: need CLOCK_XTAL/STEP_HZ >= 2 and LED_NUM >= 2");
    end
  endgenerate

  seq_state_e        r_state;
  led_mode_e         r_mode;
  bounce_dir_e       r_dir;
  logic [LED_NUM-1:0] r_pattern;
  logic              r_mode_ack;
  logic              r_step_tick;

  seq_state_e        w_state_next;
  logic [LED_NUM-1:0] w_pattern_step;
  bounce_dir_e       w_dir_step;
  logic              w_accept;
  logic              w_run_en;
  logic              w_presc_clr;
  logic              w_tc;
  logic              w_step;

  function automatic logic [LED_NUM-1:0] init_pattern(input led_mode_e mode);
    logic [LED_NUM-1:0] p;
    p = '0;
    if (mode == SHIFT || mode == BOUNCE) p[0] = 1'b1;
    return p;
  endfunction

  // A new request is only seen while no ack is outstanding, so a held
  // request re-fires every second cycle; an accept beats a coincident step.
  assign w_accept    = mode_req & ~r_mode_ack;
  assign w_run_en    = (r_state == RUN);
  assign w_presc_clr = w_accept | (r_state == IDLE);
  assign w_step      = w_run_en & w_tc & ~w_accept;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_run_en),
    .clr   (w_presc_clr),
    .tc    (w_tc)
  );

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (run)  w_state_next = RUN;
      RUN:     if (!run) w_state_next = HOLD;
      HOLD:    if (run)  w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pattern_step = r_pattern;
    w_dir_step     = r_dir;
    case (r_mode)
      BLINK: w_pattern_step = ~r_pattern;
      SHIFT: w_pattern_step = {r_pattern[LED_NUM-2:0], r_pattern[LED_NUM-1]};
      BOUNCE: begin
        // Direction flips on the step that lands on an end bit, so the end
        // bit is shown once and the next step already heads back.
        if (r_dir == DIR_UP) begin
          w_pattern_step = r_pattern << 1;
          if (r_pattern[LED_NUM-2]) w_dir_step = DIR_DOWN;
        end else begin
          w_pattern_step = r_pattern >> 1;
          if (r_pattern[1]) w_dir_step = DIR_UP;
        end
      end
      COUNT:   w_pattern_step = r_pattern + LED_NUM'(1);
      default: w_pattern_step = r_pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= BLINK;
      r_dir       <= DIR_UP;
      r_pattern   <= '0;
      r_mode_ack  <= 1'b0;
      r_step_tick <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mode_ack  <= w_accept;
      r_step_tick <= w_step;
      if (w_accept) begin
        r_mode    <= led_mode_e'(mode_sel);
        r_pattern <= init_pattern(led_mode_e'(mode_sel));
        r_dir     <= DIR_UP;
      end else if (w_step) begin
        r_pattern <= w_pattern_step;
        r_dir     <= w_dir_step;
      end
    end
  end

  assign mode_ack  = r_mode_ack;
  assign step_tick = r_step_tick;

`ifdef LED_ACTIVE_LOW_EN
  assign leds = ~r_pattern;
`else
  assign leds = r_pattern;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (DIV=10, LED_NUM=6): directed
// scenarios followed by randomized run/mode/reset traffic against a model.
module tb_led_pattern_seq;

  localparam int CLOCK_XTAL = 100;
  localparam int STEP_HZ    = 10;
  localparam int LED_NUM    = 6;
  localparam int DIV        = CLOCK_XTAL / STEP_HZ;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [5:0] POL = 6'h3F;
`else
  localparam logic [5:0] POL = 6'h00;
`endif

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;
  logic [5:0] leds;
  logic       step_tick;

  int total = 0;
  int bad   = 0;

  // Reference model: mode, number of steps taken in that mode, cycles spent
  // running in the current step period, and a coarse run/pause/idle state.
  int m_state;   // 0 idle, 1 running, 2 paused
  int m_mode;
  int m_k;
  int m_phase;
  bit m_ack;
  bit m_tick;

  logic [5:0] tick_leds[$];

  led_pattern_seq #(
    .CLOCK_XTAL (CLOCK_XTAL),
    .LED_NUM    (LED_NUM),
    .STEP_HZ    (STEP_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mode_req  (mode_req),
    .mode_sel  (mode_sel),
    .mode_ack  (mode_ack),
    .leds      (leds),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern after k steps in a mode, from the pattern rules directly.
  function automatic logic [5:0] expect_leds(input int mode, input int k);
    int m;
    int pos;
    case (mode)
      0:       return (k % 2 == 1) ? 6'h3F : 6'h00;
      1:       return 6'(1 << (k % 6));
      2: begin
        m   = k % 10;
        pos = (m <= 5) ? m : 10 - m;
        return 6'(1 << pos);
      end
      default: return 6'(k % 64);
    endcase
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit stp;
    if (!rst_n) begin
      m_state = 0; m_mode = 0; m_k = 0; m_phase = 0; m_ack = 0; m_tick = 0;
      return;
    end
    acc = mode_req && !m_ack;
    stp = (m_state == 1) && (m_phase == DIV - 1) && !acc;
    if (acc) begin
      m_mode  = int'(mode_sel);
      m_k     = 0;
      m_phase = 0;
    end else if (m_state == 1) begin
      if (m_phase == DIV - 1) begin
        m_phase = 0;
        m_k++;
      end else begin
        m_phase++;
      end
    end
    case (m_state)
      0:       if (run)  m_state = 1;
      1:       if (!run) m_state = 2;
      default: if (run)  m_state = 1;
    endcase
    m_ack  = acc;
    m_tick = stp;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("leds", leds ^ POL, expect_leds(m_mode, m_k));
    check("step_tick", {5'b0, step_tick}, {5'b0, m_tick});
    check("mode_ack", {5'b0, mode_ack}, {5'b0, m_ack});
    if (step_tick === 1'b1) tick_leds.push_back(leds ^ POL);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic request(input logic [1:0] sel);
    mode_req = 1'b1;
    mode_sel = sel;
    cycle();
    mode_req = 1'b0;
  endtask

  // Cycles until the first step_tick, 0 if none within the budget.
  task automatic cycles_to_tick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      cycle();
      if (step_tick === 1'b1 && n == 0) n = i;
      if (n != 0) break;
    end
  endtask

  initial begin
    int         n;
    logic [5:0] got;
    logic [5:0] frozen;
    logic [3:0] acks;
    int         ticks;
    logic [5:0] exp_shift[6];
    int         exp_bounce[12];

    exp_shift  = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    exp_bounce = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

    rst_n = 1'b0; run = 1'b0; mode_req = 1'b0; mode_sel = 2'd0;

    // Reset state
    cycles(2);
    check("reset_leds", leds, POL);
    check("reset_ack", {5'b0, mode_ack}, 6'd0);
    check("reset_tick", {5'b0, step_tick}, 6'd0);

    // BLINK: entry edge, then first step DIV cycles later
    rst_n = 1'b1;
    run   = 1'b1;
    cycle();
    cycles_to_tick(20, n);
    check("blink_first_tick", 6'(n), 6'(DIV));
    check("blink_step1", leds ^ POL, 6'b111111);
    cycles_to_tick(20, n);
    check("blink_period", 6'(n), 6'(DIV));
    check("blink_step2", leds ^ POL, 6'b000000);

    // SHIFT: seven steps in 70 cycles, wrap on the 6th
    request(2'd1);
    check("shift_init", leds ^ POL, 6'b000001);
    tick_leds.delete();
    cycles(70);
    check("shift_count", 6'(tick_leds.size()), 6'd7);
    for (int i = 0; i < 6; i++) begin
      got = (i < tick_leds.size()) ? tick_leds[i] : 6'bx;
      check($sformatf("shift_step%0d", i + 1), got, exp_shift[i]);
    end

    // BOUNCE: 12 steps, end bits shown once
    request(2'd2);
    tick_leds.delete();
    cycles(120);
    for (int i = 0; i < 12; i++) begin
      got = (i < tick_leds.size()) ? tick_leds[i] : 6'bx;
      check($sformatf("bounce_step%0d", i + 1), got, 6'(1 << exp_bounce[i]));
    end

    // COUNT: all-ones at step 63, with a pause mid-period before step 64
    request(2'd3);
    cycles(630);
    check("count_63", leds ^ POL, 6'b111111);
    cycles(5);
    run = 1'b0;
    tick_leds.delete();
    cycle();
    frozen = leds;
    cycles(24);
    check("pause_no_tick", 6'(tick_leds.size()), 6'd0);
    check("pause_frozen", leds, frozen);
    // 6 running cycles used before the pause: 4 remain plus the resume edge
    run = 1'b1;
    cycles_to_tick(20, n);
    check("resume_remaining", 6'(n), 6'd5);
    check("count_64_wrap", leds ^ POL, 6'b000000);

    // Request on the step cycle wins; the step is dropped
    n = 0;
    for (int i = 0; i < 20 && !(m_state == 1 && m_phase == DIV - 1); i++) begin
      cycle();
      n++;
    end
    check("reach_phase_last", 6'(m_phase), 6'(DIV - 1));
    request(2'd1);
    check("collide_ack", {5'b0, mode_ack}, 6'd1);
    check("collide_no_tick", {5'b0, step_tick}, 6'd0);
    check("collide_leds", leds ^ POL, 6'b000001);
    cycle();

    // Held request: acked every second cycle
    mode_req = 1'b1;
    mode_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      acks[3 - i] = mode_ack;
    end
    mode_req = 1'b0;
    check("held_req_acks", {2'b0, acks}, 6'b001010);

    // Reset in the middle of COUNT with a request pending
    request(2'd3);
    cycles(35);
    rst_n    = 1'b0;
    mode_req = 1'b1;
    cycle();
    check("midreset_leds", leds, POL);
    check("midreset_ack", {5'b0, mode_ack}, 6'd0);
    check("midreset_tick", {5'b0, step_tick}, 6'd0);
    rst_n    = 1'b1;
    mode_req = 1'b0;
    run      = 1'b0;
    cycles(3);
    check("idle_leds", leds ^ POL, 6'b000000);
    run = 1'b1;
    cycle();
    cycles_to_tick(20, n);
    check("post_reset_first_tick", 6'(n), 6'(DIV));

    // Randomized traffic
    ticks = 0;
    for (int i = 0; i < 3000; i++) begin
      run      = ($urandom % 8) != 0;
      mode_req = ($urandom % 12) == 0;
      mode_sel = 2'($urandom % 4);
      rst_n    = ($urandom % 400) != 0;
      cycle();
      if (step_tick === 1'b1) ticks++;
    end
    rst_n    = 1'b1;
    mode_req = 1'b0;
    check("random_saw_steps", 6'(ticks > 0), 6'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
